// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: 4-way round-robin owner of one decoder_2_4 (x/en) with hold timeout and dead cycle; ARB_FIXED_PRIO_EN selects fixed priority
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] x,
  output logic       en,
  output logic [3:0] gnt,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [1:0] w;
  logic rel;
  if (MAX_HOLD < 2 || MAX_HOLD >= 2**CNT_W) begin : g_hold_chk
    $error("MAX_HOLD must be in 2..2**CNT_W-1");
  end
`ifdef ARB_FIXED_PRIO_EN
  always_comb w = req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd3;
`else
  logic [1:0] last;
  // scan downward so the nearest requester after last wins
  always_comb begin
    w = last;
    for (int i = 4; i >= 1; i--) if (req[last + 2'(i)]) w = last + 2'(i);
  end
`endif
  assign rel = !req[x] || (cnt == CNT_W'(MAX_HOLD) && |(req & ~(4'b0001 << x)));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      en    <= 1'b0;
      gnt   <= '0;
      busy  <= 1'b0;
      cnt   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last  <= 2'd3;
`endif
    end else if (state == GRANT) begin
      if (rel) begin
        state <= GAP;
        en    <= 1'b0;
        gnt   <= '0;
      end else if (cnt != CNT_W'(MAX_HOLD)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (|req) begin
      state <= GRANT;
      x     <= w;
      en    <= 1'b1;
      gnt   <= 4'b0001 << w;
      busy  <= 1'b1;
      cnt   <= CNT_W'(1);
`ifndef ARB_FIXED_PRIO_EN
      last  <= w;
`endif
    end else begin
      state <= IDLE;
      en    <= 1'b0;
      gnt   <= '0;
      busy  <= 1'b0;
      cnt   <= '0;
    end
  end
endmodule
